muldiv_sequencer: RTL and testbench

Iterative 32-bit multiply/divide controller for the MIPS pipeline's HI/LO unit. It executes MULT, MULTU, DIV and DIVU by driving the shared external 32-bit ripple adder over many cycles: shift-add for multiply, restoring division for divide, plus sign pre- and post-correction cycles. It holds the HI/LO result registers and raises `busy` so the EX stage stalls HI/LO consumers and gives the adder to this block.

---
 rtl/muldiv_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU sequencer for the HI/LO unit, driving a shared external adder.
// state  | meaning
// IDLE   | waiting for start; adder operands held at 0
// NEG_A  | take magnitude of A (signed ops)
// NEG_B  | take magnitude of B (signed ops)
// ITER   | one shift-add or restoring-divide step per cycle
// FIX_LO | conditionally negate low result word, keep carry
// FIX_HI | conditionally negate high result word
// DONE   | hi/lo valid, done pulse
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_s,
  input  logic        add_cout
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    op_r;
  logic [CW-1:0] cnt;
  logic          sa, sb, c_r;
  logic [31:0]   a_r, b_r, w_hi, w_lo;
  logic [31:0]   div_t, iter_hi, iter_lo;
  logic          is_div, is_signed, neg_q, div_take;

  assign is_div    = op_r[1];
  assign is_signed = op_r[0];
  assign neg_q     = sa ^ sb;
  assign div_t     = {w_hi[30:0], w_lo[31]};
  // w_hi[31] is the bit shifted out of the remainder; if set, t exceeds any divisor
  assign div_take  = w_hi[31] | add_cout;

  always_comb begin
    iter_hi = {add_cout, add_s[31:1]};
    iter_lo = {add_s[0], w_lo[31:1]};
    if (is_div) begin
      iter_hi = div_take ? add_s : div_t;
      iter_lo = {w_lo[30:0], div_take};
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_NEG_A: begin
        add_a   = sa ? ~a_r : a_r;
        add_cin = sa;
      end
      S_NEG_B: begin
        add_a   = sb ? ~b_r : b_r;
        add_cin = sb;
      end
      S_ITER: begin
        if (is_div) begin
          add_a   = div_t;
          add_b   = ~b_r;
          add_cin = 1'b1;
        end else begin
          add_a = w_hi;
          add_b = w_lo[0] ? a_r : '0;
        end
      end
      S_FIX_LO: begin
        add_a   = neg_q ? ~w_lo : w_lo;
        add_cin = neg_q;
      end
      S_FIX_HI: begin
        // remainder takes the dividend's sign; product high word continues the 64-bit negate
        if (is_div) begin
          add_a   = sa ? ~w_hi : w_hi;
          add_cin = sa;
        end else begin
          add_a   = neg_q ? ~w_hi : w_hi;
          add_cin = neg_q & c_r;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_r  <= '0;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      c_r   <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      w_hi  <= '0;
      w_lo  <= '0;
    end else begin
      done <= 1'b0;
      if (flush && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              op_r <= op;
              cnt  <= '0;
              sa   <= op[0] & rs_val[31];
              sb   <= op[0] & rt_val[31];
              a_r  <= rs_val;
              b_r  <= rt_val;
              w_hi <= '0;
              w_lo <= op[1] ? rs_val : rt_val;
              busy <= 1'b1;
              if (op[1] && rt_val == '0) begin
                hi    <= rs_val;
                lo    <= '1;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= op[0] ? S_NEG_A : S_ITER;
              end
            end
          end
          S_NEG_A: begin
            a_r   <= add_s;
            state <= S_NEG_B;
          end
          S_NEG_B: begin
            b_r   <= add_s;
            w_lo  <= is_div ? a_r : add_s;
            state <= S_ITER;
          end
          S_ITER: begin
            w_hi <= iter_hi;
            w_lo <= iter_lo;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(ITER - 1)) begin
              if (is_signed) begin
                state <= S_FIX_LO;
              end else begin
                hi    <= iter_hi;
                lo    <= iter_lo;
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_FIX_LO: begin
            w_lo  <= add_s;
            c_r   <= add_cout;
            state <= S_FIX_HI;
          end
          S_FIX_HI: begin
            w_hi  <= add_s;
            hi    <= add_s;
            lo    <= w_lo;
            done  <= 1'b1;
            state <= S_DONE;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model, external adder model, random ops.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, done, add_cin, add_cout;
  logic [31:0] hi, lo, add_a, add_b, add_s;

  muldiv_sequencer #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
  );

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // MIPS HI/LO semantics straight from the arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [31:0] q, r;
    case (o)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 required no pending op (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("done_cycle", cycle, e.cyc);
          hi_m = e.hi;
          lo_m = e.lo;
        end
      end else begin
        chk("hi_hold", hi, hi_m);
        chk("lo_hold", lo, lo_m);
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
    chk({tag, "_add_cin"}, add_cin, 0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    logic [63:0] r;
    int lat;
    r = model(o, a, b);
    lat = (o[1] && b == 0) ? 0 : (o[0] ? 36 : 32);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (expect_done) sb_q.push_back('{r[63:32], r[31:0], cycle + lat});
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit seen;
    issue(o, a, b, 1'b1);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      chk("busy_during_op", busy, 1);
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else begin
        // stray requests while busy must be ignored
        start  = ($urandom_range(0, 5) == 0);
        op     = 2'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done required done for op=%0d a=%0h b=%0h", o, a, b);
    end
    @(negedge clk);
    chk_idle_outputs("after_done");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #(400000);
    $display("FAIL watchdog: got no finish required finish by 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'd1, 32'hFFFFFFFD, 32'h00000005);
    run_op(2'd1, 32'h80000000, 32'h80000000);
    run_op(2'd2, 32'd100, 32'd7);
    run_op(2'd3, 32'hFFFFFFF9, 32'd2);
    run_op(2'd3, 32'h80000000, 32'hFFFFFFFF);
    run_op(2'd2, 32'h1234, 32'h0);
    run_op(2'd3, 32'hFFFF0000, 32'h0);

    // flush mid-MULT leaves previous result intact
    run_op(2'd0, 32'd3, 32'd4);
    issue(2'd1, $urandom, $urandom, 1'b0);
    repeat (12) @(negedge clk);
    chk("busy_before_flush", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_flush");
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'd12);
    repeat (45) @(negedge clk);
    run_op(2'd2, 32'd50, 32'd5);

    for (int k = 0; k < 40; k++) run_op(2'($urandom), pick(), pick());

    // asynchronous reset mid-DIV
    issue(2'd3, 32'hDEAD0001, 32'd77, 1'b1);
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    hi_m = '0;
    lo_m = '0;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_add_a", add_a, 0);
    chk("arst_add_b", add_b, 0);
    chk("arst_add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd2, 32'd9, 32'd3);

    repeat (3) @(negedge clk);
    chk("queue_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
